gin_bus_driver: RTL and testbench
=================================

Name: gin_bus_driver

Overview:
- Upstream stage of a row of GIN multicast controllers (MCs); drives their shared tag/data/valid bus.
- Programs each MC's ID through a per-MC set_id strobe and keeps a shadow copy of every programmed ID.
- Buffers the incoming tagged packet stream in a 2-entry skid FIFO.
- Computes the match mask from the shadow IDs and issues each packet exactly once to all matching MCs. Packets whose tag matches no MC are dropped.

Parameters:
- NUM_MC, 8, number of multicast controllers on the bus
- ID_SIZE, `XID_BITS, width of tags and MC IDs
- DATA_WIDTH, 32, packet payload width
- DROP_CNT_W, 16, width of the dropped-packet counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cfg_start  in  1  pulse: begin ID programming of all MCs
- cfg_id_valid  in  1  ID stream valid
- cfg_id  in  ID_SIZE  ID for the next MC (index order 0..NUM_MC-1)
- cfg_id_ready  out  1  ID stream ready
- cfg_done  out  1  high once all MCs are programmed; level signal
- set_id  out  NUM_MC  one-hot strobe to MC k
- id_out  out  ID_SIZE  ID broadcast to all MCs' id_in
- in_valid  in  1  packet valid from GLB side
- in_ready  out  1  packet ready
- in_tag  in  ID_SIZE  packet destination tag
- in_data  in  DATA_WIDTH  packet payload
- bus_valid  out  1  to every MC valid_in
- bus_tag  out  ID_SIZE  to every MC tag
- bus_data  out  DATA_WIDTH  to every consumer behind the MCs
- mc_ready  in  NUM_MC  ready_out of each MC
- drop_pulse  out  1  one-cycle pulse per dropped packet
- drop_cnt  out  DROP_CNT_W  saturating count of dropped packets

Behaviour:
- Reset values: state=IDLE; FIFO empty; shadow IDs=0; cfg_done=0; cfg_id_ready=0; in_ready=0; set_id=0; id_out=0; bus_valid=0; drop_pulse=0; drop_cnt=0.
- Reset mid-operation: FIFO contents and the config index are discarded; cfg_done=0.
- FSM states:
  - IDLE -> CFG on cfg_start.
  - RUN -> DRAIN on cfg_start when the FIFO is non-empty; RUN -> CFG on cfg_start when the FIFO is empty.
  - DRAIN -> CFG when the FIFO is empty.
  - CFG -> RUN when the ID with index NUM_MC-1 is accepted.
  - cfg_start is ignored in DRAIN and CFG.
- CFG:
  - cfg_id_ready=1. A handshake at index k drives set_id[k]=1 and id_out=cfg_id combinationally in the same cycle, and writes shadow[k].
  - The index increments per accepted ID. cfg_done clears on entry to CFG and sets on entry to RUN.
- in_ready=1 only in RUN and only when the FIFO has a free entry; it is a registered function of the FIFO count. DRAIN, CFG and IDLE accept no packets.
- FIFO: 2 entries, each holding {tag, data}. Push on in_valid&&in_ready; pop per the rules below. Simultaneous push and pop with count=2 is impossible because in_ready=0. Push and pop in the same cycle keeps the count unchanged.
- Head entry: match[k] = (shadow[k]==head_tag). all_rdy = &(mc_ready | ~match).
- bus_tag and bus_data always present the head entry, or 0 when the FIFO is empty.
- bus_valid = !empty && (|match) && all_rdy.
  - Valid is deliberately gated by ready so no PE receives a duplicate while a co-addressed PE stalls.
  - bus_valid=1 pops the head in the same cycle, giving 0-cycle latency from head to bus.
- Drop: !empty && match==0 pops the head that cycle with bus_valid=0, drop_pulse=1 and drop_cnt+1. drop_cnt saturates at all-ones.
- Latency: a packet accepted in cycle t appears on the bus no earlier than t+1. Sustained throughput is 1 packet/cycle when all matched MCs hold ready.
- Duplicate IDs across MCs are legal and give multicast delivery; all matched MCs must be ready simultaneously.

Decomposition:
- Package gin_pkg: gin_state_e (IDLE, DRAIN, CFG, RUN) and the gin_pkt_t struct {tag, data}, parameterized via the ID_SIZE/DATA_WIDTH defines.
- Sub-module gin_skid_fifo: the 2-entry FIFO with count-based full/empty and registered in_ready.

Test Plan:
- Reset, cfg_start, then IDs 0..7 streamed back-to-back -> set_id walks 0x01..0x80 one per cycle, cfg_done=1 in the cycle after the 8th, in_ready=1 one cycle later.
- RUN; packets tag=3 data=0xA5A5_0001..0004 sent back-to-back with mc_ready=0xFF -> four bus_valid cycles in order, one/cycle, first on the cycle after the first accept.
- IDs programmed {5,5,1,1,1,1,1,1}; packet tag=5 with mc_ready=0x01 -> bus_valid=0, held; mc_ready=0x03 -> single bus_valid cycle, pop.
- Packet tag=9 with no match -> drop_pulse for 1 cycle, drop_cnt=1, bus_valid never asserts; the following tag=1 packet delivers normally.
- mc_ready=0 with 2 packets queued -> in_ready=0; release -> both packets drain, in_ready=1 again.
- cfg_start while 2 packets are queued -> DRAIN; packets deliver; then CFG; in_ready=0 throughout until the new cfg_done.

Source files
------------

// File: rtl/gin_pkg.sv
// gin_pkg: shared widths, FSM state type and packet payload for the GIN bus driver.
// Tag/ID width comes from XID_BITS and payload width from GIN_DATA_BITS when defined.
`ifndef XID_BITS
`define XID_BITS 8
`endif
`ifndef GIN_DATA_BITS
`define GIN_DATA_BITS 32
`endif

package gin_pkg;

   localparam int unsigned ID_SIZE    = `XID_BITS;
   localparam int unsigned DATA_WIDTH = `GIN_DATA_BITS;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      CFG   = 2'd2,
      RUN   = 2'd3
   } gin_state_e;

   typedef struct packed {
      logic [ID_SIZE-1:0]    tag;
      logic [DATA_WIDTH-1:0] data;
   } gin_pkt_t;

endpackage

// File: rtl/gin_skid_fifo.sv
// gin_skid_fifo: 2-entry packet FIFO with count-based empty and a registered in_ready.
// Ports:
//   clk, rst   - clock, async active-high reset (discards contents)
//   accept_en  - allow in_ready to assert in the next cycle
//   in_valid, in_pkt, in_ready - upstream packet handshake
//   pop        - drop the head entry this cycle (ignored when empty)
//   head       - head entry, all-zero when empty
//   empty      - FIFO holds no entries
module gin_skid_fifo
   import gin_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     accept_en,
   input  logic     in_valid,
   input  gin_pkt_t in_pkt,
   output logic     in_ready,
   input  logic     pop,
   output gin_pkt_t head,
   output logic     empty
);

   localparam int unsigned CNT_W = 2;

   gin_pkt_t         mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nxt;
   logic             push;
   logic             pop_ok;

   assign push   = in_valid && in_ready;
   assign empty  = (count == '0);
   assign pop_ok = pop && !empty;
   assign head   = empty ? '0 : mem[rd_ptr];

   // occupancy after this cycle's push/pop
   always_comb begin
      count_nxt = count;
      case ({push, pop_ok})
         2'b10:   count_nxt = count + CNT_W'(1);
         2'b01:   count_nxt = count - CNT_W'(1);
         default: count_nxt = count;
      endcase
   end

   // storage, pointers, and in_ready looking at next-cycle occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem[0]   <= '0;
         mem[1]   <= '0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         count    <= '0;
         in_ready <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= in_pkt;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop_ok) begin
            rd_ptr <= ~rd_ptr;
         end
         count    <= count_nxt;
         in_ready <= accept_en && (count_nxt != CNT_W'(2));
      end
   end

endmodule

// File: rtl/gin_bus_driver.sv
// gin_bus_driver: programs the IDs of a row of GIN multicast controllers, keeps shadow
// copies, buffers tagged packets and issues each one once to every matching controller.
// Ports:
//   clk, rst                      - clock, async active-high reset
//   cfg_start                     - begin (re)programming all MC IDs
//   cfg_id_valid/cfg_id/cfg_id_ready - ID stream, index order 0..NUM_MC-1
//   cfg_done                      - level, high while a complete ID set is active
//   set_id, id_out                - per-MC write strobe and broadcast ID (same cycle as handshake)
//   in_valid/in_ready/in_tag/in_data - packet stream from the GLB side
//   bus_valid/bus_tag/bus_data    - shared MC bus, head of the FIFO
//   mc_ready                      - ready from each MC
//   drop_pulse, drop_cnt          - unmatched-packet pulse and saturating count
module gin_bus_driver
   import gin_pkg::*;
#(
   parameter int unsigned NUM_MC     = 8,
   parameter int unsigned DROP_CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_start,
   input  logic                  cfg_id_valid,
   input  logic [ID_SIZE-1:0]    cfg_id,
   output logic                  cfg_id_ready,
   output logic                  cfg_done,
   output logic [NUM_MC-1:0]     set_id,
   output logic [ID_SIZE-1:0]    id_out,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ID_SIZE-1:0]    in_tag,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  bus_valid,
   output logic [ID_SIZE-1:0]    bus_tag,
   output logic [DATA_WIDTH-1:0] bus_data,
   input  logic [NUM_MC-1:0]     mc_ready,
   output logic                  drop_pulse,
   output logic [DROP_CNT_W-1:0] drop_cnt
);

   localparam int unsigned IDX_W = (NUM_MC > 1) ? $clog2(NUM_MC) : 1;

   gin_state_e         state;
   gin_state_e         state_nxt;
   logic [IDX_W-1:0]   cfg_idx;
   logic [ID_SIZE-1:0] shadow [NUM_MC];
   logic               cfg_hs;
   logic               cfg_last;
   logic               push;
   logic               pop;
   logic               accept_en;
   logic               fifo_empty;
   logic [NUM_MC-1:0]  match;
   logic               all_rdy;
   gin_pkt_t           in_pkt;
   gin_pkt_t           head;

   assign cfg_hs   = cfg_id_valid && cfg_id_ready;
   assign cfg_last = cfg_hs && (cfg_idx == IDX_W'(NUM_MC - 1));
   assign push     = in_valid && in_ready;

   assign in_pkt.tag  = in_tag;
   assign in_pkt.data = in_data;
   assign bus_tag     = head.tag;
   assign bus_data    = head.data;

   gin_skid_fifo u_fifo (
      .clk       (clk),
      .rst       (rst),
      .accept_en (accept_en),
      .in_valid  (in_valid),
      .in_pkt    (in_pkt),
      .in_ready  (in_ready),
      .pop       (pop),
      .head      (head),
      .empty     (fifo_empty)
   );

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next state plus the same-cycle outputs: the ID strobe and the issue/drop decision.
   // bus_valid waits for every matched MC so a co-addressed stall never causes duplicates.
   always_comb begin
      state_nxt  = state;
      set_id     = '0;
      id_out     = '0;
      match      = '0;
      all_rdy    = 1'b0;
      bus_valid  = 1'b0;
      drop_pulse = 1'b0;
      pop        = 1'b0;
      accept_en  = 1'b0;

      case (state)
         IDLE:    if (cfg_start) state_nxt = CFG;
         RUN:     if (cfg_start) state_nxt = (!fifo_empty || push) ? DRAIN : CFG;
         DRAIN:   if (fifo_empty) state_nxt = CFG;
         CFG:     if (cfg_last) state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase

      if (cfg_hs) begin
         set_id = NUM_MC'(1) << cfg_idx;
         id_out = cfg_id;
      end

      for (int unsigned k = 0; k < NUM_MC; k++) begin
         match[k] = (shadow[k] == head.tag);
      end
      all_rdy    = &(mc_ready | ~match);
      bus_valid  = !fifo_empty && (|match) && all_rdy;
      drop_pulse = !fifo_empty && (match == '0);
      pop        = bus_valid || drop_pulse;

      // in_ready must be low in the first RUN cycle and on the cycle leaving RUN
      accept_en  = (state == RUN) && (state_nxt == RUN);
   end

   // config index, shadow IDs, cfg_id_ready and cfg_done
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg_idx      <= '0;
         cfg_id_ready <= 1'b0;
         cfg_done     <= 1'b0;
         for (int unsigned k = 0; k < NUM_MC; k++) begin
            shadow[k] <= '0;
         end
      end else begin
         if (state != CFG)  cfg_idx <= '0;
         else if (cfg_hs)   cfg_idx <= cfg_idx + IDX_W'(1);

         if (cfg_hs) shadow[cfg_idx] <= cfg_id;

         cfg_id_ready <= (state_nxt == CFG);

         if ((state_nxt == CFG) && (state != CFG))      cfg_done <= 1'b0;
         else if ((state_nxt == RUN) && (state == CFG)) cfg_done <= 1'b1;
      end
   end

   // saturating dropped-packet counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_cnt <= '0;
      end else if (drop_pulse && (drop_cnt != '1)) begin
         drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_gin_bus_driver.sv
// tb_gin_bus_driver: directed sequences, a vector table and random traffic checked against
// a packet-queue reference model of the GIN bus driver.
module tb_gin_bus_driver;

   localparam int NMC = 8;
   localparam int IDW = gin_pkg::ID_SIZE;
   localparam int DW  = gin_pkg::DATA_WIDTH;
   localparam int DCW = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic           cfg_start;
   logic           cfg_id_valid;
   logic [IDW-1:0] cfg_id;
   logic           cfg_id_ready;
   logic           cfg_done;
   logic [NMC-1:0] set_id;
   logic [IDW-1:0] id_out;
   logic           in_valid;
   logic           in_ready;
   logic [IDW-1:0] in_tag;
   logic [DW-1:0]  in_data;
   logic           bus_valid;
   logic [IDW-1:0] bus_tag;
   logic [DW-1:0]  bus_data;
   logic [NMC-1:0] mc_ready;
   logic           drop_pulse;
   logic [DCW-1:0] drop_cnt;

   gin_bus_driver #(.NUM_MC(NMC), .DROP_CNT_W(DCW)) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_start    (cfg_start),
      .cfg_id_valid (cfg_id_valid),
      .cfg_id       (cfg_id),
      .cfg_id_ready (cfg_id_ready),
      .cfg_done     (cfg_done),
      .set_id       (set_id),
      .id_out       (id_out),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_tag       (in_tag),
      .in_data      (in_data),
      .bus_valid    (bus_valid),
      .bus_tag      (bus_tag),
      .bus_data     (bus_data),
      .mc_ready     (mc_ready),
      .drop_pulse   (drop_pulse),
      .drop_cnt     (drop_cnt)
   );

   always #5 clk = ~clk;

   // reference model: packets accepted but not yet issued/dropped, in order
   typedef struct {
      logic [IDW-1:0] tag;
      logic [DW-1:0]  data;
   } pkt_t;

   typedef struct {
      bit             v;
      logic [IDW-1:0] tag;
      logic [DW-1:0]  data;
      logic [NMC-1:0] rdy;
      bit             e_bv;
      bit             e_dp;
      logic [IDW-1:0] e_tag;
      int             e_cnt;
   } vec_t;

   pkt_t           q[$];
   logic [IDW-1:0] shadow_m [NMC];
   int             exp_drop;
   bit             exp_run;
   bit             pop_m;
   bit             drop_m;
   bit             last_acc;
   int             n_chk;
   int             n_fail;

   vec_t           tbl [12];
   logic [IDW-1:0] ids_seq [NMC];
   logic [IDW-1:0] ids_mc  [NMC];
   logic [IDW-1:0] ids_rnd [NMC];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // compare this cycle's outputs with the model, decide accept/pop
   task automatic sample();
      logic [NMC-1:0] m;
      bit             exp_bv;
      bit             exp_dp;
      bit             exp_rdy;
      logic [IDW-1:0] etag;
      logic [DW-1:0]  edata;
      @(negedge clk);
      m = '0; exp_bv = 1'b0; exp_dp = 1'b0; etag = '0; edata = '0;
      if (q.size() != 0) begin
         etag  = q[0].tag;
         edata = q[0].data;
         for (int k = 0; k < NMC; k++) m[k] = (shadow_m[k] == etag);
         exp_dp = (m == '0);
         exp_bv = (m != '0) && ((m & ~mc_ready) == '0);
      end
      exp_rdy = exp_run && (q.size() < 2);
      check("bus_valid",  64'(bus_valid),  64'(exp_bv));
      check("drop_pulse", 64'(drop_pulse), 64'(exp_dp));
      check("bus_tag",    64'(bus_tag),    64'(etag));
      check("bus_data",   64'(bus_data),   64'(edata));
      check("in_ready",   64'(in_ready),   64'(exp_rdy));
      check("drop_cnt",   64'(drop_cnt),   64'(exp_drop));
      if (!cfg_id_valid) check("set_id_idle", 64'(set_id), 64'(0));
      pop_m    = exp_bv || exp_dp;
      drop_m   = exp_dp;
      last_acc = in_valid && exp_rdy;
   endtask

   task automatic advance();
      @(posedge clk);
      if (pop_m) void'(q.pop_front());
      if (drop_m && exp_drop < 65535) exp_drop++;
      if (last_acc) q.push_back('{in_tag, in_data});
      #1;
   endtask

   task automatic tick();
      sample();
      advance();
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic send(input logic [IDW-1:0] t, input logic [DW-1:0] d, output int n);
      n = 0;
      in_valid = 1'b1; in_tag = t; in_data = d;
      do begin
         tick();
         n++;
      end while (!last_acc && n < 64);
      check("send_accept", 64'(last_acc), 64'(1));
   endtask

   task automatic model_reset();
      q.delete();
      exp_drop = 0;
      exp_run  = 1'b0;
      for (int k = 0; k < NMC; k++) shadow_m[k] = '0;
   endtask

   task automatic check_reset_outs();
      check("rst_in_ready",     64'(in_ready),     64'(0));
      check("rst_bus_valid",    64'(bus_valid),    64'(0));
      check("rst_drop_pulse",   64'(drop_pulse),   64'(0));
      check("rst_drop_cnt",     64'(drop_cnt),     64'(0));
      check("rst_cfg_done",     64'(cfg_done),     64'(0));
      check("rst_cfg_id_ready", 64'(cfg_id_ready), 64'(0));
      check("rst_set_id",       64'(set_id),       64'(0));
      check("rst_id_out",       64'(id_out),       64'(0));
      check("rst_bus_tag",      64'(bus_tag),      64'(0));
      check("rst_bus_data",     64'(bus_data),     64'(0));
   endtask

   // async reset asserted mid-cycle, released after the next edge
   task automatic pulse_reset();
      rst = 1'b1;
      #2;
      model_reset();
      check_reset_outs();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // cfg_start pulse, then wait (draining if needed) until CFG accepts IDs
   task automatic cfg_begin();
      int n;
      n = 0;
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      exp_run   = 1'b0;
      while (!cfg_id_ready && n < 64) begin
         tick();
         n++;
      end
      check("cfg_enter", 64'(cfg_id_ready), 64'(1));
      check("cfg_done_clr", 64'(cfg_done), 64'(0));
   endtask

   task automatic cfg_stream(input logic [IDW-1:0] ids [NMC]);
      for (int k = 0; k < NMC; k++) begin
         cfg_id_valid = 1'b1;
         cfg_id       = ids[k];
         cfg_start    = (k == 3);
         sample();
         check("cfg_id_ready", 64'(cfg_id_ready), 64'(1));
         check("cfg_done_low", 64'(cfg_done), 64'(0));
         check("set_id", 64'(set_id), 64'(1) << k);
         check("id_out", 64'(id_out), 64'(ids[k]));
         advance();
      end
      cfg_id_valid = 1'b0;
      cfg_id       = '0;
      cfg_start    = 1'b0;
      for (int k = 0; k < NMC; k++) shadow_m[k] = ids[k];
      sample();
      check("cfg_done_set", 64'(cfg_done), 64'(1));
      check("cfg_id_ready_low", 64'(cfg_id_ready), 64'(0));
      advance();
      exp_run = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      // IDs {5,5,1,...}: tag 5 -> MC0/1, tag 1 -> MC2..7, tag 9 unmatched
      tbl[0]  = '{1'b1, 8'd5, 32'h1111, 8'h01, 1'b0, 1'b0, 8'd0, 0};
      tbl[1]  = '{1'b0, 8'd0, 32'h0,    8'h01, 1'b0, 1'b0, 8'd5, 0};
      tbl[2]  = '{1'b0, 8'd0, 32'h0,    8'h01, 1'b0, 1'b0, 8'd5, 0};
      tbl[3]  = '{1'b0, 8'd0, 32'h0,    8'h03, 1'b1, 1'b0, 8'd5, 0};
      tbl[4]  = '{1'b1, 8'd9, 32'h2222, 8'hFF, 1'b0, 1'b0, 8'd0, 0};
      tbl[5]  = '{1'b1, 8'd1, 32'h3333, 8'hFF, 1'b0, 1'b1, 8'd9, 0};
      tbl[6]  = '{1'b0, 8'd0, 32'h0,    8'hFF, 1'b1, 1'b0, 8'd1, 1};
      tbl[7]  = '{1'b0, 8'd0, 32'h0,    8'hFF, 1'b0, 1'b0, 8'd0, 1};
      tbl[8]  = '{1'b1, 8'd1, 32'h4444, 8'hFC, 1'b0, 1'b0, 8'd0, 1};
      tbl[9]  = '{1'b0, 8'd0, 32'h0,    8'h7C, 1'b0, 1'b0, 8'd1, 1};
      tbl[10] = '{1'b0, 8'd0, 32'h0,    8'hFC, 1'b1, 1'b0, 8'd1, 1};
      tbl[11] = '{1'b0, 8'd0, 32'h0,    8'hFF, 1'b0, 1'b0, 8'd0, 1};
      for (int k = 0; k < NMC; k++) begin
         ids_seq[k] = IDW'(k);
         ids_mc[k]  = (k < 2) ? IDW'(5) : IDW'(1);
      end

      n_chk = 0; n_fail = 0;
      pop_m = 1'b0; drop_m = 1'b0; last_acc = 1'b0;
      rst = 1'b1; cfg_start = 1'b0; cfg_id_valid = 1'b0; cfg_id = '0;
      in_valid = 1'b0; in_tag = '0; in_data = '0; mc_ready = '1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_outs();
      rst = 1'b0;
      idle(2);

      // program IDs 0..7, then back-to-back packets to MC3
      cfg_begin();
      cfg_stream(ids_seq);
      mc_ready = '1;
      for (int i = 1; i <= 4; i++) begin
         send(8'd3, 32'hA5A5_0000 + DW'(i), n);
         check("b2b_accept_cycles", 64'(n), 64'(1));
      end
      idle(4);

      // multicast with partial readiness, drop, normal delivery
      cfg_begin();
      cfg_stream(ids_mc);
      for (int i = 0; i < 12; i++) begin
         in_valid = tbl[i].v; in_tag = tbl[i].tag; in_data = tbl[i].data; mc_ready = tbl[i].rdy;
         sample();
         check($sformatf("tbl%0d_bus_valid", i),  64'(bus_valid),  64'(tbl[i].e_bv));
         check($sformatf("tbl%0d_drop_pulse", i), 64'(drop_pulse), 64'(tbl[i].e_dp));
         check($sformatf("tbl%0d_bus_tag", i),    64'(bus_tag),    64'(tbl[i].e_tag));
         check($sformatf("tbl%0d_drop_cnt", i),   64'(drop_cnt),   64'(tbl[i].e_cnt));
         advance();
      end
      in_valid = 1'b0;

      // back-pressure: two queued packets fill the FIFO
      mc_ready = '0;
      send(8'd1, 32'h5001, n);
      send(8'd1, 32'h5002, n);
      in_valid = 1'b1; in_tag = 8'd1; in_data = 32'h5003;
      repeat (3) tick();
      check("bp_in_ready_low", 64'(in_ready), 64'(0));
      mc_ready = '1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!last_acc && n < 16);
      check("bp_third_accept", 64'(last_acc), 64'(1));
      idle(3);

      // cfg_start with two packets queued: drain then reconfigure
      mc_ready = '0;
      send(8'd5, 32'h6001, n);
      send(8'd5, 32'h6002, n);
      idle(1);
      mc_ready = '1;
      cfg_begin();
      check("drain_empty", 64'(q.size()), 64'(0));
      cfg_stream(ids_seq);

      // random traffic, then random (possibly duplicate) IDs
      for (int ph = 0; ph < 2; ph++) begin
         if (ph == 1) begin
            for (int k = 0; k < NMC; k++) ids_rnd[k] = IDW'($urandom_range(0, 7));
            in_valid = 1'b0;
            mc_ready = '1;
            cfg_begin();
            cfg_stream(ids_rnd);
         end
         for (int c = 0; c < 300; c++) begin
            if (!in_valid || last_acc) begin
               in_valid = ($urandom_range(0, 3) != 0);
               in_tag   = IDW'($urandom_range(0, 11));
               in_data  = $urandom;
            end
            mc_ready = ($urandom_range(0, 3) == 0) ? NMC'($urandom) : '1;
            tick();
         end
      end
      in_valid = 1'b0;
      mc_ready = '1;
      idle(4);

      // reset with packets queued, then reset in the middle of programming
      mc_ready = '0;
      send(8'd2, 32'h7001, n);
      send(8'd2, 32'h7002, n);
      idle(1);
      pulse_reset();
      mc_ready = '1;
      idle(2);
      cfg_begin();
      for (int k = 0; k < 3; k++) begin
         cfg_id_valid = 1'b1;
         cfg_id = IDW'(k + 1);
         tick();
      end
      cfg_id_valid = 1'b0;
      pulse_reset();
      idle(1);
      cfg_begin();
      cfg_stream(ids_seq);
      send(8'd6, 32'h8001, n);
      idle(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
